// File: rtl/mc_cmd_arbiter.sv
// mc_cmd_arbiter: round-robin, bank-ready-gated sharing of the memory-controller
// command port between NUM_REQ requesters, with an in-order tag FIFO that routes
// returning read data back to the requester that issued the read.
// Optional macro MC_ARB_AGE_EN adds per-requester wait counters; a requester that
// has waited MAX_WAIT cycles overrides round-robin (lowest index wins ties).
module mc_cmd_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned CMD_W     = 34,
  parameter int unsigned TAG_DEPTH = 16,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                        clk,
  input  logic                        power_on_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]    req_command,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [CMD_W-1:0]            command,
  output logic [DATA_W-1:0]           write_data,
  output logic                        valid,
  input  logic [7:0]                  ba_cmd_pm,
  input  logic [DATA_W-1:0]           read_data,
  input  logic                        read_data_valid,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        err_underflow
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_AW = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W  = TAG_AW + 1;
  localparam int unsigned RW_BIT = 31;

  logic [CMD_W-1:0]  cmd_arr   [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [CMD_W-1:0]   gnt_cmd;
  logic [IDX_W-1:0]   rr_ptr;

  logic [IDX_W-1:0]  tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr;
  logic [TAG_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]  tag_cnt;
  logic              tag_full;
  logic              tag_empty;
  logic              push;
  logic              pop;

  // Unpack the flat requester buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_arr[g]   = req_command[g*CMD_W +: CMD_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);

  // Eligibility: valid, target bank ready, and a free tag slot for reads (pre-pop count)
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & ba_cmd_pm[cmd_arr[i][2:0]] & (~cmd_arr[i][RW_BIT] | ~tag_full);
    end
  end

`ifdef MC_ARB_AGE_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0]  wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] aged;

  // Saturating wait counters: count while pending and not granted, clear on grant
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (req_valid[i] && (wait_cnt[i] != WAIT_W'(MAX_WAIT))) begin
          wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
        end
      end
    end
  end

  // Requesters that have hit the starvation limit
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_REQ; i++) aged[i] = (wait_cnt[i] == WAIT_W'(MAX_WAIT));
  end
`endif

  // Grant: first eligible at or after rr_ptr (wrapping); aged requesters take priority
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
`ifdef MC_ARB_AGE_EN
    begin
      logic aged_hit;
      aged_hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!aged_hit && elig[i] && aged[i]) begin
          aged_hit = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = IDX_W'(i);
        end
      end
    end
`endif
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign gnt_cmd   = cmd_arr[gnt_idx];
  assign push      = gnt_any & gnt_cmd[RW_BIT];
  assign pop       = read_data_valid & ~tag_empty;
  assign outstanding = tag_cnt;

  // Registered issue to the controller and round-robin pointer update
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      valid      <= 1'b0;
      command    <= '0;
      write_data <= '0;
      rr_ptr     <= '0;
    end else if (gnt_any) begin
      valid      <= 1'b1;
      command    <= gnt_cmd;
      write_data <= gnt_cmd[RW_BIT] ? '0 : wdata_arr[gnt_idx];
      rr_ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end else begin
      valid   <= 1'b0;
      command <= '0;
    end
  end

  // Tag storage: requester index of each issued read, in issue order
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + TAG_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + TAG_AW'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Route returning read data to the head-of-FIFO requester; flag untagged data
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop) begin
        rsp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
        rsp_data  <= read_data;
      end else begin
        rsp_valid <= '0;
      end
      if (read_data_valid && tag_empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_cmd_arbiter.sv
// Directed self-checking bench for mc_cmd_arbiter (default build, two requesters).
module tb_mc_cmd_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 128;
  localparam int unsigned CW = 34;
  localparam int unsigned TD = 16;
  localparam int unsigned OW = $clog2(TD) + 1;

  logic              clk;
  logic              power_on_rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*CW-1:0]  req_command;
  logic [NR*DW-1:0]  req_wdata;
  logic [CW-1:0]     command;
  logic [DW-1:0]     write_data;
  logic              valid;
  logic [7:0]        ba_cmd_pm;
  logic [DW-1:0]     read_data;
  logic              read_data_valid;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [OW-1:0]     outstanding;
  logic              err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  mc_cmd_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .CMD_W(CW), .TAG_DEPTH(TD), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .power_on_rst(power_on_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_command(req_command), .req_wdata(req_wdata),
    .command(command), .write_data(write_data), .valid(valid),
    .ba_cmd_pm(ba_cmd_pm),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    power_on_rst    = 1'b1;
    req_valid       = '0;
    req_command     = '0;
    req_wdata       = '0;
    read_data       = '0;
    read_data_valid = 1'b0;
    ba_cmd_pm       = 8'hFF;
    @(posedge clk);
    #1;
    power_on_rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] mk(input logic [1:0] rank, input logic rw,
                                       input logic [12:0] row, input logic [9:0] col,
                                       input logic [2:0] bank);
    return {rank, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
  endfunction

  logic [CW-1:0] c0, c1;
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] da, db, dc;
  int g0, g1;

  initial begin
    reset_dut();
    power_on_rst = 1'b1;
    #1;
    check("rst_valid", DW'(valid), DW'(0));
    check("rst_command", DW'(command), DW'(0));
    check("rst_wdata", write_data, DW'(0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("rst_rsp_data", rsp_data, DW'(0));
    check("rst_outstanding", DW'(outstanding), DW'(0));
    check("rst_err", DW'(err_underflow), DW'(0));
    reset_dut();

    // Single requester, four back-to-back writes to bank 0
    for (int i = 0; i < 4; i++) begin
      c0 = mk(2'd1, 1'b0, 13'(100 + i), 10'(8 * i), 3'd0);
      d0 = {4{32'hA000_0000 + 32'(i)}};
      req_valid   = 2'b01;
      req_command = {CW'(0), c0};
      req_wdata   = {DW'(0), d0};
      #1 check("t1_ready", DW'(req_ready), DW'(2'b01));
      cyc();
      check("t1_valid", DW'(valid), DW'(1));
      check("t1_cmd", DW'(command), DW'(c0));
      check("t1_wdata", write_data, d0);
    end
    req_valid = '0;
    cyc();
    check("t1_idle_valid", DW'(valid), DW'(0));
    check("t1_idle_cmd", DW'(command), DW'(0));
    check("t1_wdata_hold", write_data, d0);

    // Both requesters continuously valid: strict alternation starting at 0
    reset_dut();
    c0 = mk(2'd0, 1'b0, 13'd7, 10'd1, 3'd0);
    c1 = mk(2'd2, 1'b0, 13'd9, 10'd2, 3'd0);
    d0 = {4{32'h0000_C0DE}};
    d1 = {4{32'h0000_BEEF}};
    req_valid   = 2'b11;
    req_command = {c1, c0};
    req_wdata   = {d1, d0};
    g0 = 0;
    g1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1 check("t2_ready", DW'(req_ready), (i % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      g0 += int'(req_ready[0]);
      g1 += int'(req_ready[1]);
      cyc();
      check("t2_cmd", DW'(command), (i % 2 == 0) ? DW'(c0) : DW'(c1));
      check("t2_wdata", write_data, (i % 2 == 0) ? d0 : d1);
    end
    check("t2_share0", DW'(g0), DW'(4));
    check("t2_share1", DW'(g1), DW'(4));
    req_valid = '0;

    // Bank gating: requester 0 blocked on bank 2 until ba_cmd_pm[2] rises
    reset_dut();
    c0 = mk(2'd0, 1'b0, 13'd1, 10'd3, 3'd2);
    c1 = mk(2'd0, 1'b0, 13'd2, 10'd4, 3'd1);
    d0 = {4{32'h1111_0000}};
    req_valid   = 2'b11;
    req_command = {c1, c0};
    req_wdata   = {DW'(5), d0};
    ba_cmd_pm   = 8'hFB;
    #1 check("t3_ready_a", DW'(req_ready), DW'(2'b10));
    cyc();
    check("t3_cmd_a", DW'(command), DW'(c1));
    #1 check("t3_ready_b", DW'(req_ready), DW'(2'b10));
    cyc();
    ba_cmd_pm = 8'hFF;
    #1 check("t3_ready_c", DW'(req_ready), DW'(2'b01));
    cyc();
    check("t3_cmd_c", DW'(command), DW'(c0));
    check("t3_wdata_c", write_data, d0);

    // Interleaved reads 0,1,0 then three returns A,B,C (write_data must go to 0)
    c0 = mk(2'd3, 1'b1, 13'd20, 10'd5, 3'd3);
    c1 = mk(2'd1, 1'b1, 13'd21, 10'd6, 3'd5);
    req_command = {c1, c0};
    req_wdata   = {DW'(77), DW'(66)};
    req_valid   = 2'b01;
    cyc();
    check("t4_cmd0", DW'(command), DW'(c0));
    check("t4_rd_wdata", write_data, DW'(0));
    check("t4_out1", DW'(outstanding), DW'(1));
    req_valid = 2'b10;
    cyc();
    check("t4_cmd1", DW'(command), DW'(c1));
    check("t4_out2", DW'(outstanding), DW'(2));
    req_valid = 2'b01;
    cyc();
    check("t4_out3", DW'(outstanding), DW'(3));
    req_valid = '0;
    da = {4{32'hAAAA_0001}};
    db = {4{32'hBBBB_0002}};
    dc = {4{32'hCCCC_0003}};
    read_data_valid = 1'b1;
    read_data = da;
    cyc();
    check("t4_rspv_a", DW'(rsp_valid), DW'(2'b01));
    check("t4_rspd_a", rsp_data, da);
    check("t4_out_a", DW'(outstanding), DW'(2));
    read_data = db;
    cyc();
    check("t4_rspv_b", DW'(rsp_valid), DW'(2'b10));
    check("t4_rspd_b", rsp_data, db);
    check("t4_out_b", DW'(outstanding), DW'(1));
    read_data = dc;
    cyc();
    check("t4_rspv_c", DW'(rsp_valid), DW'(2'b01));
    check("t4_rspd_c", rsp_data, dc);
    check("t4_out_c", DW'(outstanding), DW'(0));
    read_data_valid = 1'b0;
    read_data = '0;
    cyc();
    check("t4_rspv_idle", DW'(rsp_valid), DW'(0));
    check("t4_rspd_hold", rsp_data, dc);
    check("t4_no_err", DW'(err_underflow), DW'(0));

    // Tag FIFO full: reads blocked, writes still pass, same-cycle pop frees nothing
    reset_dut();
    c0 = mk(2'd0, 1'b1, 13'd30, 10'd7, 3'd0);
    c1 = mk(2'd0, 1'b0, 13'd31, 10'd8, 3'd0);
    d1 = {4{32'h5A5A_5A5A}};
    req_command = {c1, c0};
    req_wdata   = {d1, DW'(0)};
    req_valid   = 2'b01;
    for (int i = 0; i < 16; i++) cyc();
    check("t5_out16", DW'(outstanding), DW'(16));
    #1 check("t5_rd_blocked", DW'(req_ready), DW'(0));
    req_valid = 2'b11;
    #1 check("t5_wr_pass_a", DW'(req_ready), DW'(2'b10));
    cyc();
    check("t5_wr_cmd", DW'(command), DW'(c1));
    check("t5_wr_data", write_data, d1);
    #1 check("t5_wr_pass_b", DW'(req_ready), DW'(2'b10));
    cyc();
    check("t5_out_still16", DW'(outstanding), DW'(16));
    req_valid = 2'b01;
    read_data_valid = 1'b1;
    read_data = da;
    #1 check("t5_prepop_full", DW'(req_ready), DW'(0));
    cyc();
    read_data_valid = 1'b0;
    check("t5_out15", DW'(outstanding), DW'(15));
    check("t5_valid0", DW'(valid), DW'(0));
    #1 check("t5_rd_again", DW'(req_ready), DW'(2'b01));
    cyc();
    check("t5_out16b", DW'(outstanding), DW'(16));
    req_valid = '0;

    // Underflow: read data with an empty FIFO
    reset_dut();
    read_data_valid = 1'b1;
    read_data = db;
    cyc();
    read_data_valid = 1'b0;
    check("t6_err", DW'(err_underflow), DW'(1));
    check("t6_no_rsp", DW'(rsp_valid), DW'(0));
    check("t6_out0", DW'(outstanding), DW'(0));
    cyc();
    check("t6_err_sticky", DW'(err_underflow), DW'(1));

    // Asynchronous reset with five reads in flight
    reset_dut();
    req_command = {c1, c0};
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) cyc();
    check("t7_out5", DW'(outstanding), DW'(5));
    check("t7_valid1", DW'(valid), DW'(1));
    #2;
    power_on_rst = 1'b1;
    req_valid = '0;
    #1;
    check("t7_valid", DW'(valid), DW'(0));
    check("t7_cmd", DW'(command), DW'(0));
    check("t7_wdata", write_data, DW'(0));
    check("t7_rspv", DW'(rsp_valid), DW'(0));
    check("t7_out", DW'(outstanding), DW'(0));
    check("t7_err", DW'(err_underflow), DW'(0));
    cyc();
    power_on_rst = 1'b0;
    read_data_valid = 1'b1;
    cyc();
    read_data_valid = 1'b0;
    check("t7_tags_dropped", DW'(err_underflow), DW'(1));
    check("t7_no_rsp", DW'(rsp_valid), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_cmd_arbiter.md
Name: mc_cmd_arbiter

Overview:
- Shares the memory-controller access-command port (34-bit command, 128-bit write_data, valid) between NUM_REQ requesters, e.g. two image-stream engines.
- Arbitration is round-robin, gated per bank by the controller's ba_cmd_pm ready vector.
- Every issued read is tagged with its requester ID in an in-order tag FIFO, so returning read_data is routed back to the right requester.
- Sits directly between the requesters and the memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 128, write/read data width (DQ_BITS*8)
- CMD_W, 34, command width: {rank[33:32], rw[31], 0, row[29:17], 0, bl, 0, auto_pre, col[12:3], bank[2:0]}
- TAG_DEPTH, 16, max outstanding reads (power of 2)
- MAX_WAIT, 15, starvation limit in cycles (used only with the optional feature)

Ports:
- clk, in, 1, system clock, all state on posedge
- power_on_rst, in, 1, asynchronous active-high reset
- req_valid, in, NUM_REQ, per-requester command valid
- req_ready, out, NUM_REQ, per-requester accept (one-hot or zero)
- req_command, in, NUM_REQ*CMD_W, packed commands; requester i at [i*CMD_W +: CMD_W]
- req_wdata, in, NUM_REQ*DATA_W, packed write data
- command, out, CMD_W, command to the controller
- write_data, out, DATA_W, write data to the controller
- valid, out, 1, command valid to the controller
- ba_cmd_pm, in, 8, per-bank "can accept" from the controller
- read_data, in, DATA_W, read data from the controller
- read_data_valid, in, 1, read data strobe
- rsp_valid, out, NUM_REQ, per-requester read-data strobe
- rsp_data, out, DATA_W, routed read data
- outstanding, out, $clog2(TAG_DEPTH)+1, reads in flight
- err_underflow, out, 1, sticky: read data arrived with no tag

Behaviour:
- Reset: valid=0, command=0, write_data=0, rsp_valid=0, rsp_data=0, outstanding=0, err_underflow=0, RR pointer=0, tag FIFO empty. Reset mid-operation drops all in-flight tags.
- Eligibility of requester i: req_valid[i] AND ba_cmd_pm[cmd_i[2:0]] AND (cmd_i[31]==0 OR outstanding<TAG_DEPTH).
  - The full check uses the pre-pop count: a same-cycle pop does not free a slot.
- Grant:
  - Combinational, one-hot. The first eligible requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready = grant. A transfer happens when req_valid & req_ready.
- Issue (registered, 1-cycle latency):
  - On grant, at the next posedge: command<=granted cmd, valid<=1, and write_data<=granted wdata for writes or 0 for reads.
  - RR pointer <= grant index+1, wrapping.
  - With no grant: valid<=0 and command<=0. write_data holds its value.
- Throughput: one command per cycle. Back-to-back grants to different requesters are allowed.
- Tag FIFO:
  - Issued read (cmd[31]==1): push the requester index.
  - read_data_valid: pop the head.
  - Push and pop in the same cycle are both performed; the count is unchanged.
- Response (registered, 1-cycle latency): on read_data_valid with a non-empty FIFO, next cycle rsp_valid[head]=1 (one-hot) and rsp_data=read_data. Otherwise rsp_valid=0 and rsp_data holds.
- Empty FIFO on read_data_valid: data is dropped, err_underflow is set (sticky until reset), and outstanding stays 0.
- A ba_cmd_pm deassert on the granted bank only affects the current cycle's eligibility. A granted command has already been sampled and is never retracted.
- ba_cmd_pm index is bank[2:0]. rank bits pass through untouched.

Optional Feature:
- Macro: MC_ARB_AGE_EN.
- Defined:
  - Each requester keeps a wait counter. It increments while req_valid is high and the requester is not granted, clears on grant, and saturates at MAX_WAIT.
  - An eligible requester whose counter == MAX_WAIT overrides round-robin; ties go to the lowest index.
  - The RR pointer still advances past the granted index.
- Undefined: pure round-robin, and no counters are synthesized.

Test Plan:
- Single requester 0 issues 4 writes to bank 0, ba_cmd_pm=8'hFF -> valid high for 4 consecutive cycles, each 1 cycle after acceptance, with command/write_data matching the inputs.
- Both requesters continuously valid, bank 0, all ready -> grants alternate 0,1,0,1. Each gets 50% of 8 cycles.
- Requester 0 targets bank 2 with ba_cmd_pm[2]=0; requester 1 targets bank 1 -> only requester 1 is granted. Raising ba_cmd_pm[2] grants requester 0 next cycle.
- Reads: requesters 0,1,0 interleaved, then 3 read_data_valid pulses with data A,B,C -> rsp_valid one-hot 01,10,01 carrying A,B,C. outstanding goes 3→0.
- Issue 16 reads -> outstanding=16 and further reads are not granted while writes still proceed. A read_data_valid with an empty FIFO -> err_underflow=1 and no rsp_valid.
- Assert power_on_rst with 5 reads outstanding -> all outputs return to reset values immediately. With MC_ARB_AGE_EN, a requester held off for 15 cycles is granted on cycle 16.
